// File: rtl/decode_scoreboard.sv
// Decode-stage register/CC scoreboard: per-register in-flight write counters drive
// the dependency stall and the AGEX valid bit, with optional writeback bypass.
module decode_scoreboard #(
    parameter int NUM_REGS     = 8,
    parameter int REG_ID_W     = 3,
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2,
    parameter bit WB_BYPASS    = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_de_v,
    input  logic                i_sr1_needed,
    input  logic                i_sr2_needed,
    input  logic [REG_ID_W-1:0] i_sr1,
    input  logic [REG_ID_W-1:0] i_sr2,
    input  logic                i_dr_we,
    input  logic [REG_ID_W-1:0] i_dr,
    input  logic                i_cc_we,
    input  logic                i_br_op,
    input  logic                i_ld_agex,
    input  logic                i_wb_ld_reg,
    input  logic [REG_ID_W-1:0] i_wb_drid,
    input  logic                i_wb_ld_cc,
    input  logic                i_kill_ld_reg,
    input  logic                i_kill_ld_cc,
    input  logic [REG_ID_W-1:0] i_kill_drid,
    output logic                o_dep_stall,
    output logic                o_agex_v,
    output logic [NUM_REGS-1:0] o_reg_busy,
    output logic                o_cc_busy,
    output logic [CNT_W-1:0]    o_inflight,
    output logic                o_sb_err
);

    // Returns {err, next}: clamps at 0 on underflow, saturates on overflow.
    function automatic logic [CNT_W:0] f_step(input logic [CNT_W-1:0] cur,
                                              input logic inc, input logic d1,
                                              input logic d2);
        logic [CNT_W:0] up, dn, df;
        up = {1'b0, cur} + {{CNT_W{1'b0}}, inc};
        dn = {{CNT_W{1'b0}}, d1} + {{CNT_W{1'b0}}, d2};
        if (up < dn) return {1'b1, {CNT_W{1'b0}}};
        df = up - dn;
        if (df[CNT_W]) return {1'b1, {CNT_W{1'b1}}};
        return {1'b0, df[CNT_W-1:0]};
    endfunction

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [CNT_W-1:0]    r_cc_cnt;
    logic [CNT_W-1:0]    r_inflight;
    logic                r_sb_err;

    logic [CNT_W-1:0]    w_sr1_cnt, w_sr2_cnt;
    logic                w_sr1_hz, w_sr2_hz, w_cc_hz, w_struct_hz;
    logic                w_issue, w_release;
    logic [NUM_REGS-1:0] w_reg_err;
    logic [CNT_W:0]      w_cc_step, w_inf_step;

    // Out-of-range source IDs match no register and so read as count 0.
    always_comb begin
        w_sr1_cnt = '0;
        w_sr2_cnt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (i_sr1 == REG_ID_W'(r)) w_sr1_cnt = r_cnt[r];
            if (i_sr2 == REG_ID_W'(r)) w_sr2_cnt = r_cnt[r];
        end
    end

    assign w_sr1_hz = i_sr1_needed && (w_sr1_cnt != '0) &&
                      !(WB_BYPASS && (w_sr1_cnt == CNT_W'(1)) && i_wb_ld_reg && (i_wb_drid == i_sr1));
    assign w_sr2_hz = i_sr2_needed && (w_sr2_cnt != '0) &&
                      !(WB_BYPASS && (w_sr2_cnt == CNT_W'(1)) && i_wb_ld_reg && (i_wb_drid == i_sr2));
    assign w_cc_hz  = i_br_op && (r_cc_cnt != '0) &&
                      !(WB_BYPASS && (r_cc_cnt == CNT_W'(1)) && i_wb_ld_cc);

    assign w_release   = i_wb_ld_reg | i_wb_ld_cc | i_kill_ld_reg | i_kill_ld_cc;
    assign w_struct_hz = (i_dr_we | i_cc_we) && (r_inflight == CNT_W'(MAX_INFLIGHT)) && !w_release;

    assign o_dep_stall = i_de_v & (w_sr1_hz | w_sr2_hz | w_cc_hz | w_struct_hz);
    assign o_agex_v    = i_de_v & ~o_dep_stall;
    assign w_issue     = o_agex_v & i_ld_agex;

    assign w_cc_step  = f_step(r_cc_cnt, w_issue & i_cc_we, i_wb_ld_cc, i_kill_ld_cc);
    assign w_inf_step = f_step(r_inflight, w_issue & (i_dr_we | i_cc_we),
                               i_wb_ld_reg | i_wb_ld_cc, i_kill_ld_reg | i_kill_ld_cc);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [CNT_W:0] w_step;
        assign w_step = f_step(r_cnt[g],
                               w_issue & i_dr_we & (i_dr == REG_ID_W'(g)),
                               i_wb_ld_reg & (i_wb_drid == REG_ID_W'(g)),
                               i_kill_ld_reg & (i_kill_drid == REG_ID_W'(g)));
        assign w_reg_err[g]  = w_step[CNT_W];
        assign o_reg_busy[g] = (r_cnt[g] != '0);

        always_ff @(posedge i_clk) begin
            if (i_reset) r_cnt[g] <= '0;
            else         r_cnt[g] <= w_step[CNT_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cc_cnt   <= '0;
            r_inflight <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            r_cc_cnt   <= w_cc_step[CNT_W-1:0];
            r_inflight <= w_inf_step[CNT_W-1:0];
            r_sb_err   <= r_sb_err | (|w_reg_err) | w_cc_step[CNT_W] | w_inf_step[CNT_W];
        end
    end

    assign o_cc_busy  = (r_cc_cnt != '0);
    assign o_inflight = r_inflight;
    assign o_sb_err   = r_sb_err;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: one instance without and one with the
// writeback bypass, driven by the same stimulus.
module tb_decode_scoreboard;
    logic       clk = 1'b0;
    logic       reset;
    logic       de_v, sr1_needed, sr2_needed, dr_we, cc_we, br_op, ld_agex;
    logic       wb_ld_reg, wb_ld_cc, kill_ld_reg, kill_ld_cc;
    logic [2:0] sr1, sr2, dr, wb_drid, kill_drid;

    logic       stall0, agexv0, ccb0, err0, stall1, agexv1, ccb1, err1;
    logic [7:0] busy0, busy1;
    logic [1:0] inf0, inf1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_scoreboard #(.WB_BYPASS(1'b0)) u_dut0 (
        .i_clk(clk), .i_reset(reset), .i_de_v(de_v), .i_sr1_needed(sr1_needed),
        .i_sr2_needed(sr2_needed), .i_sr1(sr1), .i_sr2(sr2), .i_dr_we(dr_we), .i_dr(dr),
        .i_cc_we(cc_we), .i_br_op(br_op), .i_ld_agex(ld_agex), .i_wb_ld_reg(wb_ld_reg),
        .i_wb_drid(wb_drid), .i_wb_ld_cc(wb_ld_cc), .i_kill_ld_reg(kill_ld_reg),
        .i_kill_ld_cc(kill_ld_cc), .i_kill_drid(kill_drid), .o_dep_stall(stall0),
        .o_agex_v(agexv0), .o_reg_busy(busy0), .o_cc_busy(ccb0), .o_inflight(inf0),
        .o_sb_err(err0));

    decode_scoreboard #(.WB_BYPASS(1'b1)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_de_v(de_v), .i_sr1_needed(sr1_needed),
        .i_sr2_needed(sr2_needed), .i_sr1(sr1), .i_sr2(sr2), .i_dr_we(dr_we), .i_dr(dr),
        .i_cc_we(cc_we), .i_br_op(br_op), .i_ld_agex(ld_agex), .i_wb_ld_reg(wb_ld_reg),
        .i_wb_drid(wb_drid), .i_wb_ld_cc(wb_ld_cc), .i_kill_ld_reg(kill_ld_reg),
        .i_kill_ld_cc(kill_ld_cc), .i_kill_drid(kill_drid), .o_dep_stall(stall1),
        .o_agex_v(agexv1), .o_reg_busy(busy1), .o_cc_busy(ccb1), .o_inflight(inf1),
        .o_sb_err(err1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        de_v = 0; sr1_needed = 0; sr2_needed = 0; dr_we = 0; cc_we = 0; br_op = 0;
        ld_agex = 1; wb_ld_reg = 0; wb_ld_cc = 0; kill_ld_reg = 0; kill_ld_cc = 0;
        sr1 = 0; sr2 = 0; dr = 0; wb_drid = 0; kill_drid = 0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic issue_wr(input logic [2:0] r);
        idle();
        de_v = 1; dr_we = 1; dr = r;
        step();
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        step();
        step();
        reset = 0;
        #1;
        chk("rst_busy", {24'd0, busy0}, 32'h00);
        chk("rst_ccb", {31'd0, ccb0}, 32'd0);
        chk("rst_inf", {30'd0, inf0}, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);

        // Source reads with all counters idle, then issue a writer to R3
        de_v = 1; sr1_needed = 1; sr1 = 3; #1;
        chk("idle_stall", {31'd0, stall0}, 32'd0);
        chk("idle_agexv", {31'd0, agexv0}, 32'd1);
        dr_we = 1; dr = 3;
        step();
        idle(); #1;
        chk("iss_busy", {24'd0, busy0}, 32'h08);
        chk("iss_inf", {30'd0, inf0}, 32'd1);

        // Dependent on R3 with no retire: both variants stall
        de_v = 1; sr1_needed = 1; sr1 = 3; dr_we = 1; dr = 4; #1;
        chk("dep_stall0", {31'd0, stall0}, 32'd1);
        chk("dep_stall1", {31'd0, stall1}, 32'd1);
        chk("dep_agexv0", {31'd0, agexv0}, 32'd0);
        // Same cycle as R3 retires: only the bypass variant issues
        wb_ld_reg = 1; wb_drid = 3; #1;
        chk("wb_stall0", {31'd0, stall0}, 32'd1);
        chk("wb_stall1", {31'd0, stall1}, 32'd0);
        chk("wb_agexv1", {31'd0, agexv1}, 32'd1);
        step();
        idle(); #1;
        chk("wb_busy0", {24'd0, busy0}, 32'h00);
        chk("wb_inf0", {30'd0, inf0}, 32'd0);
        chk("wb_busy1", {24'd0, busy1}, 32'h10);
        chk("wb_inf1", {30'd0, inf1}, 32'd1);
        // Without bypass the dependent issues the cycle after retirement
        de_v = 1; sr1_needed = 1; sr1 = 3; #1;
        chk("post_wb_stall0", {31'd0, stall0}, 32'd0);

        // ld_agex low blocks issue; then issue + retire to the same register
        do_reset();
        de_v = 1; dr_we = 1; dr = 6; ld_agex = 0;
        step();
        idle(); #1;
        chk("noload_busy", {24'd0, busy0}, 32'h00);
        chk("noload_inf", {30'd0, inf0}, 32'd0);
        issue_wr(3'd2);
        de_v = 1; dr_we = 1; dr = 2; wb_ld_reg = 1; wb_drid = 2; #1;
        chk("waw_stall", {31'd0, stall0}, 32'd0);
        step();
        idle(); #1;
        chk("waw_busy", {24'd0, busy0}, 32'h04);
        chk("waw_inf", {30'd0, inf0}, 32'd1);
        chk("waw_err", {31'd0, err0}, 32'd0);

        // CC writer in flight; branch stalls, kill clears it
        do_reset();
        de_v = 1; cc_we = 1;
        step();
        idle(); #1;
        chk("cc_busy", {31'd0, ccb0}, 32'd1);
        de_v = 1; br_op = 1; #1;
        chk("br_stall0", {31'd0, stall0}, 32'd1);
        chk("br_stall1", {31'd0, stall1}, 32'd1);
        kill_ld_cc = 1;
        step();
        idle(); #1;
        chk("kill_ccb", {31'd0, ccb0}, 32'd0);
        chk("kill_inf", {30'd0, inf0}, 32'd0);
        de_v = 1; br_op = 1; #1;
        chk("br_go", {31'd0, agexv0}, 32'd1);

        // Structural limit at three in-flight writers
        do_reset();
        issue_wr(3'd0);
        issue_wr(3'd1);
        issue_wr(3'd2);
        chk("full_inf", {30'd0, inf0}, 32'd3);
        de_v = 1; dr_we = 1; dr = 4; #1;
        chk("full_stall", {31'd0, stall0}, 32'd1);
        wb_ld_reg = 1; wb_drid = 0; #1;
        chk("full_wb_stall", {31'd0, stall0}, 32'd0);
        step();
        idle(); #1;
        chk("full_inf2", {30'd0, inf0}, 32'd3);
        chk("full_busy", {24'd0, busy0}, 32'h16);

        // Retire of an idle register: clamp and sticky error
        do_reset();
        wb_ld_reg = 1; wb_drid = 5;
        step();
        idle(); #1;
        chk("uf_busy", {24'd0, busy0}, 32'h00);
        chk("uf_inf", {30'd0, inf0}, 32'd0);
        chk("uf_err", {31'd0, err0}, 32'd1);
        step();
        chk("uf_sticky", {31'd0, err0}, 32'd1);
        // Reset wins over a concurrent issue
        de_v = 1; dr_we = 1; dr = 7; reset = 1;
        step();
        reset = 0;
        idle(); #1;
        chk("rst_mid_err", {31'd0, err0}, 32'd0);
        chk("rst_mid_busy", {24'd0, busy0}, 32'h00);
        chk("rst_mid_inf", {30'd0, inf0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Parametrised register/condition-code scoreboard for the decode stage of the LC-3b pipeline. It replaces per-stage destination-ID comparators with per-register in-flight write counters, so pipeline depth and register count are parameters. It also adds an optional writeback bypass, squash (kill) handling and a structural in-flight limit. It sits beside the control store and register file in decode and produces `dep_stall` and `agex_v` for the decode/AGEX latch.

## Interface
Parameters:
- `NUM_REGS`, 8, architectural registers tracked.
- `REG_ID_W`, 3, register-ID width; `2**REG_ID_W >= NUM_REGS`.
- `MAX_INFLIGHT`, 3, maximum issued-but-unretired instructions that write a register or CC.
- `CNT_W`, 2, counter width; `2**CNT_W - 1 >= MAX_INFLIGHT`.
- `WB_BYPASS`, 0. When 1, a source retiring this cycle with count 1 does not stall.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `de_v`  in  1  decode latch holds a valid instruction.
- `sr1_needed`, `sr2_needed`  in  1  source operands used (control-store bits).
- `sr1`, `sr2`  in  REG_ID_W  source register IDs.
- `dr_we`  in  1  instruction writes `dr`.
- `dr`  in  REG_ID_W  destination register ID.
- `cc_we`  in  1  instruction writes condition codes.
- `br_op`  in  1  instruction reads condition codes.
- `ld_agex`  in  1  AGEX latch loads this cycle (`~mem_stall`).
- `wb_ld_reg`  in  1  valid register write retiring this cycle.
- `wb_drid`  in  REG_ID_W  retiring destination ID.
- `wb_ld_cc`  in  1  valid CC write retiring this cycle.
- `kill_ld_reg`, `kill_ld_cc`  in  1  squashed in-flight instruction had the reg/CC write.
- `kill_drid`  in  REG_ID_W  squashed destination ID.
- `dep_stall`  out  1  decode must hold.
- `agex_v`  out  1  valid bit into AGEX (`de_v & ~dep_stall`).
- `reg_busy`  out  NUM_REGS  bit i = `cnt[i] != 0`.
- `cc_busy`  out  1  `cc_cnt != 0`.
- `inflight`  out  CNT_W  total in-flight writers.
- `sb_err`  out  1  sticky over/underflow flag.

## Operation
- State:
  - `cnt[NUM_REGS]` of CNT_W bits;
  - `cc_cnt` of CNT_W bits;
  - `inflight` of CNT_W bits;
  - `sb_err`.
- Reset: all counters 0, `sb_err` 0. Outputs after reset: `reg_busy=0`, `cc_busy=0`, `inflight=0`, `dep_stall=0`, `agex_v=de_v`.
- Source hazard: `srN_hz = srN_needed & cnt[srN] != 0`.
  - With `WB_BYPASS=1`, the hazard is suppressed when `cnt[srN]==1 & wb_ld_reg & wb_drid==srN`.
  - The same rule applies to CC: `br_op & cc_cnt!=0`, bypassed on `cc_cnt==1 & wb_ld_cc`.
- Structural hazard: `(dr_we|cc_we) & inflight==MAX_INFLIGHT & ~(retire or kill this cycle)`.
- `dep_stall = de_v & (sr1_hz | sr2_hz | cc_hz | struct_hz)`.
- `issue = de_v & ~dep_stall & ld_agex`.
- Per-register next count: `cnt[r] + (issue & dr_we & dr==r) - (wb_ld_reg & wb_drid==r) - (kill_ld_reg & kill_drid==r)`. The net change is in the range -2..+1, applied in the same cycle.
- `cc_cnt` uses `issue&cc_we`, `wb_ld_cc` and `kill_ld_cc` the same way.
- `inflight`:
  - increments on `issue & (dr_we|cc_we)`;
  - decrements once per retiring instruction (`wb_ld_reg|wb_ld_cc`);
  - decrements once per killed instruction (`kill_ld_reg|kill_ld_cc`).
- Underflow (decrement would take a count below 0): the counter clamps at 0 and `sb_err` sets.
- Overflow (increment above `2**CNT_W-1`): the counter saturates and `sb_err` sets.
- `sb_err` clears only on reset.
- `dr`/`sr` values `>= NUM_REGS` are ignored: no hazard, no count change.
- WAW (issue to a register already busy) is legal; the count accumulates.

## Timing
- `dep_stall`, `agex_v` and hazards are combinational from inputs and current state, with zero latency.
- Counter updates become visible the cycle after issue, retire or kill.
- Issue then a dependent instruction next cycle: the dependent instruction sees `cnt=1` and stalls until the cycle after retirement (`WB_BYPASS=0`), or until the retirement cycle itself (`WB_BYPASS=1`).
- `ld_agex=0` blocks issue; counters hold except for retire/kill.
- Reset asserted mid-operation clears all state at the next edge regardless of other inputs.

## Test plan
- Reset, then `de_v=1, sr1_needed=1, sr1=3`, all counters 0 -> `dep_stall=0`, `agex_v=1`. Issue `dr_we=1, dr=3` -> next cycle `reg_busy=8'h08`, `inflight=1`.
- `cnt[3]=1`, dependent `sr1=3`, `wb_ld_reg=1, wb_drid=3`:
  - `WB_BYPASS=0` -> `dep_stall=1`, then `cnt[3]=0`;
  - `WB_BYPASS=1` -> `dep_stall=0`, issue accepted.
- `cnt[2]=1`, same-cycle issue `dr=2` and retire `wb_drid=2` -> `cnt[2]` stays 1, `inflight` unchanged.
- `cc_cnt=1, br_op=1` -> stall. Then `kill_ld_cc=1` -> `cc_cnt=0`, `cc_busy=0`, branch issues next cycle.
- `inflight=MAX_INFLIGHT=3`, new writer with no retire -> `dep_stall=1`. Add `wb_ld_reg=1` in the same cycle -> issue accepted, `inflight` stays 3.
- `cnt[5]=0`, `wb_ld_reg=1, wb_drid=5` -> `cnt[5]=0`, `sb_err=1` sticky until `reset`.
